// File: rtl/nn_ctrl_pkg.sv
// Shared constants, register map and types for the neural_net inference controller.
package nn_ctrl_pkg;

  localparam int N_IN  = 64;
  localparam int N_OUT = 8;

  localparam logic [6:0] ADDR_X0     = 7'd0;
  localparam logic [6:0] ADDR_O0     = 7'd64;
  localparam logic [6:0] ADDR_CTRL   = 7'd72;
  localparam logic [6:0] ADDR_STATUS = 7'd73;
  localparam logic [6:0] ADDR_CLASS  = 7'd74;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_ARGMAX,
    ST_DONE
  } nn_state_t;

  typedef logic [31:0]           fp32_t;
  typedef fp32_t [N_IN-1:0]      x_vec_t;
  typedef fp32_t [N_OUT-1:0]     o_vec_t;

  // Merge a write into an existing word, one byte lane per enable bit.
  function automatic fp32_t apply_be(input fp32_t old_w, input fp32_t new_w,
                                     input logic [3:0] be);
    fp32_t r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_infer_ctrl_fp32_gt.sv
// Combinational IEEE-754 single-precision strict greater-than (a > b).
// NaN operands: a NaN is never greater, anything non-NaN beats a NaN.
// +0 and -0 are equal; denormals are ordered by their raw bit pattern.
module fp32_gt
  import nn_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  logic a_nan;
  logic b_nan;
  logic both_zero;

  // Sign-magnitude ordering with NaN and signed-zero special cases first.
  always_comb begin
    a_nan     = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    gt        = 1'b0;
    if (a_nan) begin
      gt = 1'b0;
    end else if (b_nan) begin
      gt = 1'b1;
    end else if (both_zero) begin
      gt = 1'b0;
    end else if (a[31] != b[31]) begin
      gt = b[31];
    end else if (!a[31]) begin
      gt = (a[30:0] > b[30:0]);
    end else begin
      gt = (a[30:0] < b[30:0]);
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// Avalon-MM controller for the 64-in / 8-out fp32 neural_net classifier:
// holds the input vector, waits for the combinational net to settle,
// latches the scores and runs a sequential argmax over them.
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [6:0]          AVL_ADDR,
  input  logic [3:0]          AVL_BYTE_EN,
  input  logic [31:0]         AVL_WRITEDATA,
  output logic [31:0]         AVL_READDATA,
  output logic                IRQ,
  output logic [N_IN*32-1:0]  NN_X,
  input  logic [N_OUT*32-1:0] NN_O
);

  nn_state_t state_q, state_d;
  x_vec_t    x_q, x_d;
  o_vec_t    o_q, o_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  fp32_t      best_q, best_d;
  logic [2:0] best_idx_q, best_idx_d;
  logic [2:0] class_q, class_d;
  logic       done_q, done_d;
  logic       irq_q, irq_d;

  logic  busy;
  logic  wr_x;
  logic  start_req;
  fp32_t cur;
  logic  cur_gt;

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE) ||
                     (state_q == ST_ARGMAX);
  assign wr_x      = AVL_CS && AVL_WRITE && !AVL_ADDR[6] && !busy;
  assign start_req = AVL_CS && AVL_WRITE && (AVL_ADDR == ADDR_CTRL) &&
                     AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign cur       = o_q[idx_q];
  assign NN_X      = x_q;
  assign IRQ       = irq_q;

  fp32_gt u_gt (
    .a  (cur),
    .b  (best_q),
    .gt (cur_gt)
  );

  // Input vector write port; frozen while a run is in flight.
  always_comb begin
    x_d = x_q;
    if (wr_x) begin
      x_d[AVL_ADDR[5:0]] = apply_be(x_q[AVL_ADDR[5:0]], AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

  // Run sequencing: settle wait, score capture, one argmax step per cycle.
  always_comb begin
    state_d    = state_q;
    o_d        = o_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    done_d     = done_q;
    irq_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          done_d  = 1'b0;
          cnt_d   = 8'(SETTLE_CYCLES);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        o_d        = NN_O;
        best_d     = NN_O[31:0];
        best_idx_d = 3'd0;
        idx_d      = 3'd1;
        state_d    = ST_ARGMAX;
      end
      ST_ARGMAX: begin
        if (cur_gt) begin
          best_d     = cur;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 3'd1;
        // Last element: publish the result directly so CLASS is valid with DONE.
        if (idx_q == 3'd7) begin
          class_d = cur_gt ? idx_q : best_idx_q;
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register update; reset aborts any run on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      o_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      o_q        <= o_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
    end
  end

  // Zero-latency register read mux; unmapped addresses and CTRL read 0.
  always_comb begin
    AVL_READDATA = 32'd0;
    if (AVL_CS && AVL_READ) begin
      if (!AVL_ADDR[6]) begin
        AVL_READDATA = x_q[AVL_ADDR[5:0]];
      end else if (AVL_ADDR < ADDR_CTRL) begin
        AVL_READDATA = o_q[AVL_ADDR[2:0]];
      end else if (AVL_ADDR == ADDR_STATUS) begin
        AVL_READDATA = {30'd0, done_q, busy};
      end else if (AVL_ADDR == ADDR_CLASS) begin
        AVL_READDATA = {29'd0, class_q};
      end
    end
  end

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// Testbench for nn_infer_ctrl: table vectors, randomized score sets against
// a key-ordering argmax model, and hand sequences for the timing corner cases.
module tb_nn_infer_ctrl;

  localparam int S = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          AVL_CS, AVL_READ, AVL_WRITE;
  logic [6:0]    AVL_ADDR;
  logic [3:0]    AVL_BYTE_EN;
  logic [31:0]   AVL_WRITEDATA;
  logic [31:0]   rdata, rdata1;
  logic          irq, irq1;
  logic [2047:0] nn_x, nn_x1;
  logic [255:0]  nn_o;

  always #5 CLK = ~CLK;

  nn_infer_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(rdata), .IRQ(irq),
    .NN_X(nn_x), .NN_O(nn_o)
  );

  nn_infer_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(rdata1), .IRQ(irq1),
    .NN_X(nn_x1), .NN_O(nn_o)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0][31:0] o;
    logic [2:0]       cls;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] mk(input logic [31:0] a0, a1, a2, a3,
                                          a4, a5, a6, a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  // Reference: map every non-NaN value onto a signed integer key whose
  // ordering matches the real-number ordering (both zeros map to 0), then
  // take the first index holding the largest key. All-NaN gives 0.
  function automatic logic [2:0] model_argmax(input logic [7:0][31:0] o);
    longint key, best_key;
    int     best;
    bit     found;
    found = 0; best = 0; best_key = 0;
    for (int i = 0; i < 8; i++) begin
      if (!(o[i][30:23] == 8'hff && o[i][22:0] != 23'd0)) begin
        key = longint'(o[i][30:0]);
        if (o[i][31]) key = -key;
        if (!found || key > best_key) begin
          found = 1; best_key = key; best = i;
        end
      end
    end
    return 3'(best);
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [7:0][31:0] prev, input int i);
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: begin r[30:23] = 8'hff; if (r[22:0] == 23'd0) r[0] = 1'b1; end
      1: r[30:0] = 31'd0;
      2: r[30:23] = 8'h00;
      3: begin r[30:23] = 8'hff; r[22:0] = 23'd0; end
      4: if (i > 0) r = prev[$urandom_range(0, i-1)];
      5: r[30:23] = 8'(126 + $urandom_range(0, 2));
      default: ;
    endcase
    return r;
  endfunction

  task automatic bus_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [31:0] d, output logic [31:0] d1);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    #1;
    d = rdata; d1 = rdata1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  // mode 0: plain run; 1: X write + START during SETTLE and START in the DONE
  // cycle; 2: reset asserted in the third ARGMAX cycle.
  task automatic run(input logic [7:0][31:0] sc, input logic [2:0] exp_cls,
                     input int mode, input string nm);
    int irq_at, irq_n, irq1_at;
    logic [31:0] rd, rd1, exp_st;
    nn_o = sc;
    if (mode == 1) bus_write(7'd5, 32'h12345678, 4'hf);
    bus_write(7'd72, 32'd1, 4'hf);
    irq_at = -1; irq_n = 0; irq1_at = -1;
    for (int k = 1; k <= 40; k++) begin
      bus_read(7'd73, rd, rd1);
      if (mode == 2) exp_st = (k <= S + 4) ? 32'd1 : 32'd0;
      else           exp_st = (k <= S + 8) ? 32'd1 : 32'd2;
      check($sformatf("%s status k=%0d", nm, k), rd, exp_st);
      if (irq) begin irq_n++; if (irq_at < 0) irq_at = k; end
      if (irq1 && irq1_at < 0) irq1_at = k;
      if (mode == 1 && k == 3) begin
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 7'd5;
        AVL_WRITEDATA = 32'h3f800000; AVL_BYTE_EN = 4'hf;
      end
      if (mode == 1 && (k == 4 || k == S + 9)) begin
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 7'd72;
        AVL_WRITEDATA = 32'd1; AVL_BYTE_EN = 4'hf;
      end
      if (mode == 2 && k == S + 4) RESET = 1'b1;
      @(posedge CLK); #1;
      AVL_CS = 1'b0; AVL_WRITE = 1'b0; RESET = 1'b0;
    end
    bus_read(7'd74, rd, rd1);
    if (mode == 2) begin
      check({nm, " irq count"}, 32'(irq_n), 32'd0);
      check({nm, " class"}, rd, 32'd0);
      bus_read(7'd64, rd, rd1);
      check({nm, " O0 cleared"}, rd, 32'd0);
      bus_read(7'd5, rd, rd1);
      check({nm, " X5 cleared"}, rd, 32'd0);
    end else begin
      check({nm, " class"}, rd, {29'd0, exp_cls});
      check({nm, " irq cycle"}, 32'(irq_at), 32'(S + 9));
      check({nm, " irq count"}, 32'(irq_n), 32'd1);
      for (int j = 0; j < 8; j++) begin
        bus_read(7'(64 + j), rd, rd1);
        check($sformatf("%s O[%0d]", nm, j), rd, sc[j]);
      end
      if (mode == 0) begin
        bus_read(7'd74, rd, rd1);
        check({nm, " S=1 class"}, rd1, {29'd0, exp_cls});
        check({nm, " S=1 irq cycle"}, 32'(irq1_at), 32'd10);
      end else begin
        bus_read(7'd5, rd, rd1);
        check({nm, " X5 frozen"}, rd, 32'h12345678);
        check({nm, " NN_X[5] frozen"}, nn_x[5*32 +: 32], 32'h12345678);
      end
    end
  endtask

  initial begin
    logic [31:0] rd, rd1;
    logic [7:0][31:0] sc;

    tbl[0].o   = mk(32'h3f55f6fd, 32'hbf085879, 32'h3d99ce07, 32'hbf24c986,
                    32'hbf3ccccd, 32'hbe31de6a, 32'hbf3b4396, 32'hbf48240b);
    tbl[0].cls = 3'd0;
    tbl[1].o   = mk(32'hbf800000, 32'h80000000, 32'h00000000, 32'h7fc00000,
                    32'hc0000000, 32'hc0400000, 32'hc0800000, 32'hff800000);
    tbl[1].cls = 3'd1;
    tbl[2].o   = mk(32'h7fc00000, 32'hffc00001, 32'h7f800001, 32'h7fffffff,
                    32'h7fc00000, 32'hff800001, 32'h7fc00000, 32'h7fc00000);
    tbl[2].cls = 3'd0;
    tbl[3].o   = mk(32'h3f800000, 32'h00000001, 32'h807fffff, 32'h40490fdb,
                    32'h40490fda, 32'hc0000000, 32'h40490fdb, 32'h00000000);
    tbl[3].cls = 3'd3;

    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = '0; AVL_BYTE_EN = '0; AVL_WRITEDATA = '0; nn_o = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    for (int a = 0; a <= 74; a++) begin
      bus_read(7'(a), rd, rd1);
      check($sformatf("reset read %0d", a), rd, 32'd0);
    end
    check("reset irq", {31'd0, irq}, 32'd0);

    bus_write(7'd0, 32'h11223344, 4'hf);
    bus_write(7'd0, 32'haabbccdd, 4'b0101);
    bus_read(7'd0, rd, rd1);
    check("byte enable X0", rd, 32'h11bb33dd);
    check("byte enable NN_X0", nn_x[31:0], 32'h11bb33dd);
    check("byte enable S=1 NN_X0", nn_x1[31:0], 32'h11bb33dd);
    bus_write(7'd63, 32'hcafef00d, 4'hf);
    bus_read(7'd63, rd, rd1);
    check("X63 read", rd, 32'hcafef00d);
    check("NN_X63", nn_x[63*32 +: 32], 32'hcafef00d);

    for (int a = 0; a < 64; a++) bus_write(7'(a), 32'd0, 4'hf);

    for (int t = 0; t < 4; t++) run(tbl[t].o, tbl[t].cls, 0, $sformatf("table%0d", t));

    run(mk(32'h3f000000, 32'hbf800000, 32'h00000000, 32'h3e800000,
           32'h7fc00000, 32'h40000000, 32'h3fffffff, 32'h40000000), 3'd5, 1, "busy");

    run(tbl[0].o, 3'd0, 2, "midreset");
    run(tbl[3].o, tbl[3].cls, 0, "after reset");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) sc[i] = rnd_fp(sc, i);
      run(sc, model_argmax(sc), 0, $sformatf("rand%0d", r));
    end

    bus_write(7'd100, 32'hdeadbeef, 4'hf);
    bus_read(7'd100, rd, rd1);
    check("unmapped read", rd, 32'd0);
    bus_read(7'd72, rd, rd1);
    check("ctrl read", rd, 32'd0);
    bus_read(7'd127, rd, rd1);
    check("top addr read", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
